// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and width helpers for the FIFO burst reader.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StDrain
  } state_e;

  // Counter width able to hold the value 0..timeout inclusive.
  function automatic int unsigned idle_timer_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_idle_timer.sv
// Saturating idle counter; hit is high once the count has reached LIMIT.
module burst_idle_timer #(
  parameter int unsigned LIMIT = 64,
  parameter int unsigned WIDTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic hit
);

  localparam logic [WIDTH-1:0] Limit = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != Limit)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == Limit);

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a simple_fifo in bounded bursts, framed as a valid/ready stream with m_last.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_ready,
  input  logic [ADDR_WIDTH:0]   fifo_count,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  burst_done,
  output logic [31:0]           burst_total
);

  localparam int unsigned    CntW     = ADDR_WIDTH + 1;
  localparam int unsigned    TimerW   = idle_timer_width(TIMEOUT);
  localparam logic [CntW-1:0] MaxBurst = CntW'(MAX_BURST);

  state_e          state_q, state_d;
  logic [CntW-1:0] remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic            m_valid_q, m_last_q;
  logic [31:0]     burst_total_q;

  logic pop, accept, start, timer_hit, timer_clear, timer_inc;

  always_comb begin
    fifo_ready  = (state_q == StBurst) && (remaining_q != '0) && (!m_valid_q || m_ready);
    pop         = fifo_ready && fifo_valid;
    accept      = m_valid_q && m_ready;
    burst_done  = accept && m_last_q;
    start       = (state_q == StIdle) &&
                  ((fifo_count >= MaxBurst) || ((fifo_count != '0) && timer_hit));
    timer_inc   = (state_q == StIdle) && (fifo_count != '0) && (fifo_count < MaxBurst);
    timer_clear = (state_q != StIdle) || (fifo_count == '0) || start;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StBurst;
          remaining_d = (fifo_count < MaxBurst) ? fifo_count : MaxBurst;
        end
      end
      StBurst: begin
        if (pop) begin
          remaining_d = remaining_q - CntW'(1);
          if (remaining_q == CntW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (burst_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      remaining_q   <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      burst_total_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      // A pop always lands in an empty or just-accepted slot, so it wins over accept.
      if (pop) begin
        m_data_q  <= fifo_data;
        m_valid_q <= 1'b1;
        m_last_q  <= (remaining_q == CntW'(1));
      end else if (accept) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
      if (burst_done) begin
        burst_total_q <= burst_total_q + 32'd1;
      end
    end
  end

  burst_idle_timer #(
    .LIMIT (TIMEOUT),
    .WIDTH (TimerW)
  ) u_idle_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .inc   (timer_inc),
    .hit   (timer_hit)
  );

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign burst_total = burst_total_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader fed by a behavioural single-clock FIFO.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_valid;
  logic [31:0] fifo_data;
  logic        fifo_ready;
  logic [5:0]  fifo_count;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic        burst_done;
  logic [31:0] burst_total;

  logic        push_en = 1'b0;
  logic [31:0] push_data = '0;
  logic        ext_pop = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .MAX_BURST  (8),
    .TIMEOUT    (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_valid  (fifo_valid),
    .fifo_data   (fifo_data),
    .fifo_ready  (fifo_ready),
    .fifo_count  (fifo_count),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .burst_done  (burst_done),
    .burst_total (burst_total)
  );

  // Behavioural 32-deep FIFO standing in for simple_fifo.
  logic [31:0] mem [32];
  logic [4:0]  wp = '0;
  logic [4:0]  rp = '0;
  logic [5:0]  cnt = '0;
  logic        do_pop;

  assign fifo_valid = (cnt != '0);
  assign fifo_data  = mem[rp];
  assign fifo_count = cnt;
  assign do_pop     = (fifo_ready && fifo_valid) || ext_pop;

  always @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_en) begin
        mem[wp] <= push_data;
        wp      <= wp + 5'd1;
      end
      if (do_pop) rp <= rp + 5'd1;
      cnt <= cnt + {5'd0, push_en} - {5'd0, do_pop};
    end
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pushes n words base..base+n-1; returns at the negedge where the last one is counted.
  task automatic push(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push_en   = 1'b1;
      push_data = 32'(base + i);
    end
    @(negedge clk);
    push_en = 1'b0;
  endtask

  // Negedges stepped until m_valid is seen (at least one step, bounded).
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid && n < 200);
  endtask

  // Expects len back-to-back words starting at the current negedge, m_ready held high.
  task automatic expect_burst(input string tag, input int len, input int base);
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      check1({tag, "_valid"}, m_valid, 1'b1);
      check32({tag, "_data"}, m_data, 32'(base + i));
      check1({tag, "_last"}, m_last, i == len - 1);
      check1({tag, "_done"}, burst_done, i == len - 1);
    end
    @(negedge clk);
    check1({tag, "_gap"}, m_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idx;
    logic [9:0] pat;

    // Reset state
    repeat (2) @(negedge clk);
    check1("rst_m_valid", m_valid, 1'b0);
    check1("rst_m_last", m_last, 1'b0);
    check32("rst_m_data", m_data, 32'd0);
    check1("rst_fifo_ready", fifo_ready, 1'b0);
    check1("rst_burst_done", burst_done, 1'b0);
    check32("rst_burst_total", burst_total, 32'd0);
    rst = 1'b0;

    // Full burst: start in cycle N, fifo_ready in N+1, m_valid in N+2
    push(8, 0);
    check1("full_idle_ready", fifo_ready, 1'b0);
    @(negedge clk);
    check1("full_first_ready", fifo_ready, 1'b1);
    check1("full_valid_early", m_valid, 1'b0);
    @(negedge clk);
    expect_burst("full", 8, 0);
    check32("full_total", burst_total, 32'd1);

    // Timeout flush: timer starts with the first word, flush 66 cycles later
    push(3, 100);
    wait_valid(n);
    check32("tmo_latency", 32'(n), 32'd64);
    expect_burst("tmo", 3, 100);
    check32("tmo_total", burst_total, 32'd2);

    // Oversized backlog held back by a stall, then released: 8, 8, 4
    m_ready = 1'b0;
    push(20, 200);
    check1("blog_stall_valid", m_valid, 1'b1);
    check32("blog_stall_data", m_data, 32'd200);
    check1("blog_stall_ready", fifo_ready, 1'b0);
    check32("blog_stall_count", 32'(fifo_count), 32'd19);
    m_ready = 1'b1;
    expect_burst("blog1", 8, 200);
    wait_valid(n);
    check32("blog2_latency", 32'(n), 32'd2);
    expect_burst("blog2", 8, 208);
    wait_valid(n);
    check32("blog3_latency", 32'(n), 32'd66);
    expect_burst("blog3", 4, 216);
    check32("blog_total", burst_total, 32'd5);

    // Backpressure: m_ready pattern 1,0,1,0,1,1,1,1,1,1 from the first valid word
    push(8, 300);
    wait_valid(n);
    check32("bp_latency", 32'(n), 32'd2);
    pat = 10'b11_1111_0101;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      check1("bp_valid", m_valid, 1'b1);
      check32("bp_data", m_data, 32'(300 + idx));
      check1("bp_last", m_last, idx == 7);
      m_ready = pat[k];
      #1;
      check1("bp_fifo_ready", fifo_ready, pat[k] && (idx < 7));
      check1("bp_done", burst_done, pat[k] && (idx == 7));
      if (pat[k]) idx++;
    end
    m_ready = 1'b1;
    @(negedge clk);
    check1("bp_gap", m_valid, 1'b0);
    check32("bp_total", burst_total, 32'd6);

    // Reset after the third word of a burst, then a clean burst
    push(8, 400);
    wait_valid(n);
    check32("mrst_latency", 32'(n), 32'd2);
    repeat (2) @(negedge clk);
    check32("mrst_word2", m_data, 32'd402);
    rst = 1'b1;
    @(negedge clk);
    check1("mrst_m_valid", m_valid, 1'b0);
    check1("mrst_m_last", m_last, 1'b0);
    check32("mrst_m_data", m_data, 32'd0);
    check1("mrst_fifo_ready", fifo_ready, 1'b0);
    check32("mrst_total", burst_total, 32'd0);
    rst = 1'b0;
    push(8, 500);
    wait_valid(n);
    check32("fresh_latency", 32'(n), 32'd2);
    expect_burst("fresh", 8, 500);
    check32("fresh_total", burst_total, 32'd1);

    // Timer clear: an empty FIFO restarts the idle count from zero
    push(1, 600);
    repeat (29) @(negedge clk);
    check1("tclr_no_flush", m_valid, 1'b0);
    ext_pop = 1'b1;
    @(negedge clk);
    ext_pop = 1'b0;
    check32("tclr_empty", 32'(fifo_count), 32'd0);
    push(1, 601);
    wait_valid(n);
    check32("tclr_latency", 32'(n), 32'd66);
    expect_burst("tclr", 1, 601);
    check32("tclr_total", burst_total, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
